// File: rtl/bsg_gateway_power_seq_pkg.sv
// rtl/bsg_gateway_power_seq_pkg.sv - state encoding and output decode for the ASIC power sequencer
package bsg_gateway_power_seq_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    IO_RAMP   = 3'd1,
    CORE_RAMP = 3'd2,
    LINK_RST  = 3'd3,
    CALIB     = 3'd4,
    UP        = 3'd5,
    FAIL      = 3'd6,
    PWR_DN    = 3'd7
  } state_e;

  typedef struct packed {
    logic io_en;
    logic core_en;
    logic link_reset;
    logic up;
    logic fail;
  } outs_t;

  localparam outs_t outs_off_lp       = 5'b00100;
  localparam outs_t outs_io_ramp_lp   = 5'b10100;
  localparam outs_t outs_core_ramp_lp = 5'b11100;
  localparam outs_t outs_link_rst_lp  = 5'b11100;
  localparam outs_t outs_calib_lp     = 5'b11000;
  localparam outs_t outs_up_lp        = 5'b11010;
  localparam outs_t outs_fail_lp      = 5'b00101;
  localparam outs_t outs_pwr_dn_lp    = 5'b10100;

  function automatic outs_t decode_outputs(input state_e s);
    case (s)
      IO_RAMP:   return outs_io_ramp_lp;
      CORE_RAMP: return outs_core_ramp_lp;
      LINK_RST:  return outs_link_rst_lp;
      CALIB:     return outs_calib_lp;
      UP:        return outs_up_lp;
      FAIL:      return outs_fail_lp;
      PWR_DN:    return outs_pwr_dn_lp;
      default:   return outs_off_lp;
    endcase
  endfunction

endpackage

// File: rtl/bsg_sync_sync.sv
// rtl/bsg_sync_sync.sv - two-flop synchronizer into the oclk domain
module bsg_sync_sync #(
  parameter int width_p = 1
) (
  input  logic               oclk_i,
  input  logic [width_p-1:0] iclk_data_i,
  output logic [width_p-1:0] oclk_data_o
);

  logic [width_p-1:0] sync_1_q;
  logic [width_p-1:0] sync_2_q;

  always_ff @(posedge oclk_i) begin
    sync_1_q <= iclk_data_i;
    sync_2_q <= sync_1_q;
  end

  assign oclk_data_o = sync_2_q;

endmodule

// File: rtl/bsg_gateway_power_seq.sv
// rtl/bsg_gateway_power_seq.sv - gateway FPGA sequencer for ASIC rails, link reset and calibration retry
module bsg_gateway_power_seq
  import bsg_gateway_power_seq_pkg::*;
#(
  parameter int io_settle_cycles_p     = 1000,
  parameter int core_settle_cycles_p   = 1000,
  parameter int link_reset_cycles_p    = 64,
  parameter int calib_timeout_cycles_p = 100000,
  parameter int max_retries_p          = 3
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic       calib_done_i,
  output logic       asic_io_en_o,
  output logic       asic_core_en_o,
  output logic       link_reset_o,
  output logic       up_o,
  output logic       fail_o,
  output logic [1:0] retry_count_o,
  output logic [2:0] state_o
);

  localparam int max_ab_lp    = (io_settle_cycles_p > core_settle_cycles_p) ? io_settle_cycles_p : core_settle_cycles_p;
  localparam int max_abc_lp   = (max_ab_lp > link_reset_cycles_p) ? max_ab_lp : link_reset_cycles_p;
  localparam int max_all_lp   = (max_abc_lp > calib_timeout_cycles_p) ? max_abc_lp : calib_timeout_cycles_p;
  localparam int ctr_width_lp = $clog2(max_all_lp + 1);
  localparam int rw_raw_lp    = $clog2(max_retries_p + 1);
  localparam int rw_lp        = (rw_raw_lp < 2) ? 2 : rw_raw_lp;

  localparam logic [ctr_width_lp-1:0] io_load_lp    = ctr_width_lp'(io_settle_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] core_load_lp  = ctr_width_lp'(core_settle_cycles_p - 1);
  localparam logic [ctr_width_lp-1:0] link_load_lp  = ctr_width_lp'(link_reset_cycles_p - 1);
  // CALIB waits the full timeout before the expiry cycle, so done can still land on that last cycle.
  localparam logic [ctr_width_lp-1:0] calib_load_lp = ctr_width_lp'(calib_timeout_cycles_p);
  localparam logic [rw_lp-1:0]        retry_max_lp  = rw_lp'(max_retries_p);

  state_e                  state_q, state_d;
  logic [ctr_width_lp-1:0] timer_q, timer_d;
  logic [rw_lp-1:0]        retry_q, retry_d;
  outs_t                   outs_q, outs_d;
  logic [1:0]              retry_out_q, retry_out_d;
  logic                    done_sync;
  logic                    timer_zero;

  bsg_sync_sync #(.width_p(1)) calib_sync (
    .oclk_i      (clk_i),
    .iclk_data_i (calib_done_i),
    .oclk_data_o (done_sync)
  );

  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = timer_zero ? '0 : timer_q - ctr_width_lp'(1);

    case (state_q)
      OFF:       if (en_i) state_d = IO_RAMP;
      IO_RAMP:   if (!en_i) state_d = PWR_DN; else if (timer_zero) state_d = CORE_RAMP;
      CORE_RAMP: if (!en_i) state_d = PWR_DN; else if (timer_zero) state_d = LINK_RST;
      LINK_RST:  if (!en_i) state_d = PWR_DN; else if (timer_zero) state_d = CALIB;
      CALIB: begin
        if (!en_i) state_d = PWR_DN;
        else if (done_sync) state_d = UP;
        else if (timer_zero) begin
          if (retry_q < retry_max_lp) begin
            retry_d = retry_q + rw_lp'(1);
            state_d = LINK_RST;
          end else begin
            state_d = FAIL;
          end
        end
      end
      UP:        if (!en_i) state_d = PWR_DN; else if (!done_sync) state_d = LINK_RST;
      FAIL:      if (!en_i) state_d = OFF;
      PWR_DN:    if (timer_zero) state_d = OFF;
      default:   state_d = OFF;
    endcase

    if (state_d != state_q) begin
      case (state_d)
        IO_RAMP:   timer_d = io_load_lp;
        CORE_RAMP: timer_d = core_load_lp;
        LINK_RST:  timer_d = link_load_lp;
        CALIB:     timer_d = calib_load_lp;
        PWR_DN:    timer_d = core_load_lp;
        default:   timer_d = '0;
      endcase
    end

    if (state_d == OFF) retry_d = '0;

    outs_d      = decode_outputs(state_d);
    retry_out_d = (retry_d > rw_lp'(3)) ? 2'd3 : retry_d[1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= OFF;
      timer_q     <= '0;
      retry_q     <= '0;
      outs_q      <= outs_off_lp;
      retry_out_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      outs_q      <= outs_d;
      retry_out_q <= retry_out_d;
    end
  end

  assign asic_io_en_o   = outs_q.io_en;
  assign asic_core_en_o = outs_q.core_en;
  assign link_reset_o   = outs_q.link_reset;
  assign up_o           = outs_q.up;
  assign fail_o         = outs_q.fail;
  assign retry_count_o  = retry_out_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_bsg_gateway_power_seq.sv
// tb/tb_bsg_gateway_power_seq.sv - directed bench for the ASIC power sequencer
module tb_bsg_gateway_power_seq;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic       en_i = 1'b0;
  logic       calib_done_i = 1'b0;
  logic       asic_io_en_o, asic_core_en_o, link_reset_o, up_o, fail_o;
  logic [1:0] retry_count_o;
  logic [2:0] state_o;
  logic [9:0] obs;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // {io_en, core_en, link_reset, up, fail, retry_count[1:0], state[2:0]}
  localparam logic [9:0] E_OFF   = 10'b0010000000;
  localparam logic [9:0] E_IO    = 10'b1010000001;
  localparam logic [9:0] E_CORE  = 10'b1110000010;
  localparam logic [9:0] E_LRST0 = 10'b1110000011;
  localparam logic [9:0] E_LRST1 = 10'b1110001011;
  localparam logic [9:0] E_LRST2 = 10'b1110010011;
  localparam logic [9:0] E_CAL0  = 10'b1100000100;
  localparam logic [9:0] E_CAL2  = 10'b1100010100;
  localparam logic [9:0] E_UP0   = 10'b1101000101;
  localparam logic [9:0] E_FAIL2 = 10'b0010110110;
  localparam logic [9:0] E_PDN   = 10'b1010000111;

  assign obs = {asic_io_en_o, asic_core_en_o, link_reset_o, up_o, fail_o, retry_count_o, state_o};

  always #5 clk_i = ~clk_i;

  bsg_gateway_power_seq #(
    .io_settle_cycles_p     (4),
    .core_settle_cycles_p   (6),
    .link_reset_cycles_p    (3),
    .calib_timeout_cycles_p (20),
    .max_retries_p          (2)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .en_i           (en_i),
    .calib_done_i   (calib_done_i),
    .asic_io_en_o   (asic_io_en_o),
    .asic_core_en_o (asic_core_en_o),
    .link_reset_o   (link_reset_o),
    .up_o           (up_o),
    .fail_o         (fail_o),
    .retry_count_o  (retry_count_o),
    .state_o        (state_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  task automatic go(input int c);
    while (cyc < c) step();
  endtask

  task automatic restart();
    reset_n_i = 1'b0;
    en_i = 1'b0;
    calib_done_i = 1'b0;
    repeat (3) step();
    reset_n_i = 1'b1;
    en_i = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    restart();
    total++; if (obs !== E_OFF) begin bad++; $display("FAIL reset_state got=%b want=%b", obs, E_OFF); end
  endtask

  task automatic test_bringup();
    go(1);  total++; if (obs !== E_IO)    begin bad++; $display("FAIL up_c1_io got=%b want=%b", obs, E_IO); end
    go(4);  total++; if (obs !== E_IO)    begin bad++; $display("FAIL up_c4_io got=%b want=%b", obs, E_IO); end
    go(5);  total++; if (obs !== E_CORE)  begin bad++; $display("FAIL up_c5_core got=%b want=%b", obs, E_CORE); end
    go(10); total++; if (obs !== E_CORE)  begin bad++; $display("FAIL up_c10_core got=%b want=%b", obs, E_CORE); end
    go(11); total++; if (obs !== E_LRST0) begin bad++; $display("FAIL up_c11_lrst got=%b want=%b", obs, E_LRST0); end
    go(13); total++; if (obs !== E_LRST0) begin bad++; $display("FAIL up_c13_lrst got=%b want=%b", obs, E_LRST0); end
    go(14); total++; if (obs !== E_CAL0)  begin bad++; $display("FAIL up_c14_calib got=%b want=%b", obs, E_CAL0); end
    go(16); calib_done_i = 1'b1;
    go(18); total++; if (obs !== E_CAL0)  begin bad++; $display("FAIL up_c18_sync_lat got=%b want=%b", obs, E_CAL0); end
    go(19); total++; if (obs !== E_UP0)   begin bad++; $display("FAIL up_c19_up got=%b want=%b", obs, E_UP0); end
  endtask

  task automatic test_retry_fail();
    restart();
    go(34); total++; if (obs !== E_CAL0)  begin bad++; $display("FAIL rt_c34_calib got=%b want=%b", obs, E_CAL0); end
    go(35); total++; if (obs !== E_LRST1) begin bad++; $display("FAIL rt_c35_retry1 got=%b want=%b", obs, E_LRST1); end
    go(59); total++; if (obs !== E_LRST2) begin bad++; $display("FAIL rt_c59_retry2 got=%b want=%b", obs, E_LRST2); end
    go(82); total++; if (obs !== E_CAL2)  begin bad++; $display("FAIL rt_c82_calib got=%b want=%b", obs, E_CAL2); end
    go(83); total++; if (obs !== E_FAIL2) begin bad++; $display("FAIL rt_c83_fail got=%b want=%b", obs, E_FAIL2); end
    go(86); total++; if (obs !== E_FAIL2) begin bad++; $display("FAIL rt_fail_hold got=%b want=%b", obs, E_FAIL2); end
  endtask

  task automatic test_fail_recover();
    en_i = 1'b0;
    go(87); total++; if (obs !== E_OFF) begin bad++; $display("FAIL fr_off got=%b want=%b", obs, E_OFF); end
    en_i = 1'b1;
    go(88); total++; if (obs !== E_IO)  begin bad++; $display("FAIL fr_reseq got=%b want=%b", obs, E_IO); end
  endtask

  task automatic test_reset_mid();
    restart();
    go(7); total++; if (obs !== E_CORE) begin bad++; $display("FAIL rm_core got=%b want=%b", obs, E_CORE); end
    reset_n_i = 1'b0;
    go(8); total++; if (obs !== E_OFF)  begin bad++; $display("FAIL rm_reset_vals got=%b want=%b", obs, E_OFF); end
    reset_n_i = 1'b1;
    go(9); total++; if (obs !== E_IO)   begin bad++; $display("FAIL rm_reseq got=%b want=%b", obs, E_IO); end
  endtask

  task automatic test_done_on_timeout();
    restart();
    go(32); calib_done_i = 1'b1;
    go(34); total++; if (obs !== E_CAL0) begin bad++; $display("FAIL to_c34_calib got=%b want=%b", obs, E_CAL0); end
    go(35); total++; if (obs !== E_UP0)  begin bad++; $display("FAIL to_c35_up got=%b want=%b", obs, E_UP0); end
  endtask

  task automatic test_link_drop();
    go(40); calib_done_i = 1'b0;
    go(42); total++; if (obs !== E_UP0)   begin bad++; $display("FAIL ld_c42_up got=%b want=%b", obs, E_UP0); end
    go(43); total++; if (obs !== E_LRST0) begin bad++; $display("FAIL ld_c43_lrst got=%b want=%b", obs, E_LRST0); end
    go(45); total++; if (obs !== E_LRST0) begin bad++; $display("FAIL ld_c45_lrst got=%b want=%b", obs, E_LRST0); end
    calib_done_i = 1'b1;
    go(46); total++; if (obs !== E_CAL0)  begin bad++; $display("FAIL ld_c46_calib got=%b want=%b", obs, E_CAL0); end
    go(47); total++; if (obs !== E_CAL0)  begin bad++; $display("FAIL ld_c47_calib got=%b want=%b", obs, E_CAL0); end
    go(48); total++; if (obs !== E_UP0)   begin bad++; $display("FAIL ld_c48_up got=%b want=%b", obs, E_UP0); end
  endtask

  task automatic test_power_down();
    go(55); en_i = 1'b0;
    go(56); total++; if (obs !== E_PDN) begin bad++; $display("FAIL pd_c56_pdn got=%b want=%b", obs, E_PDN); end
    en_i = 1'b1;
    go(61); total++; if (obs !== E_PDN) begin bad++; $display("FAIL pd_c61_pdn got=%b want=%b", obs, E_PDN); end
    go(62); total++; if (obs !== E_OFF) begin bad++; $display("FAIL pd_c62_off got=%b want=%b", obs, E_OFF); end
    go(63); total++; if (obs !== E_IO)  begin bad++; $display("FAIL pd_c63_reseq got=%b want=%b", obs, E_IO); end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_retry_fail();
    test_fail_recover();
    test_reset_mid();
    test_done_on_timeout();
    test_link_drop();
    test_power_down();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
